// File: rtl/psram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the single-port PSRAM controller.
// Round-robin grant per Wishbone cycle, with a per-transaction ack watchdog.
module psram_wb_arbiter #(
    parameter int unsigned TIMEOUT_CLKS = 64,
    parameter int unsigned ADDR_W       = 22
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_stb_i,
    input  logic              m0_cyc_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [31:0]       m0_data_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [31:0]       m0_data_o,

    input  logic              m1_stb_i,
    input  logic              m1_cyc_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [31:0]       m1_data_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [31:0]       m1_data_o,

    output logic              s_stb_o,
    output logic              s_cyc_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [31:0]       s_data_o,
    input  logic              s_ack_i,
    input  logic [31:0]       s_data_i
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR_HOLD} state_t;

    localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CLKS);

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic [7:0]  timer;
    logic        err_q;

    logic              req0, req1, pick1, busy;
    logic              sel_stb, sel_cyc, sel_we;
    logic [3:0]        sel_sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_data;

    always_comb begin
        req0  = m0_cyc_i & m0_stb_i;
        req1  = m1_cyc_i & m1_stb_i;
        // On contention the master that did not win last time gets the slot.
        pick1 = req1 & (~req0 | ~last_grant);
        busy  = (state == BUSY);

        sel_stb  = grant ? m1_stb_i  : m0_stb_i;
        sel_cyc  = grant ? m1_cyc_i  : m0_cyc_i;
        sel_we   = grant ? m1_we_i   : m0_we_i;
        sel_sel  = grant ? m1_sel_i  : m0_sel_i;
        sel_addr = grant ? m1_addr_i : m0_addr_i;
        sel_data = grant ? m1_data_i : m0_data_i;

        s_stb_o  = busy & sel_stb;
        s_cyc_o  = busy & sel_cyc;
        s_we_o   = busy & sel_we;
        s_sel_o  = busy ? sel_sel  : '0;
        s_addr_o = busy ? sel_addr : '0;
        s_data_o = busy ? sel_data : '0;

        m0_ack_o  = busy & ~grant & s_ack_i;
        m1_ack_o  = busy &  grant & s_ack_i;
        m0_data_o = (busy & ~grant) ? s_data_i : '0;
        m1_data_o = (busy &  grant) ? s_data_i : '0;
        m0_err_o  = err_q & ~grant;
        m1_err_o  = err_q &  grant;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            timer      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    err_q <= 1'b0;
                    if (req0 | req1) begin
                        grant      <= pick1;
                        last_grant <= pick1;
                        timer      <= TIMEOUT_LOAD;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (!sel_cyc) begin
                        state <= IDLE;
                    end else if (s_stb_o) begin
                        // An ack on the expiry clock still completes the access.
                        if (s_ack_i) begin
                            timer <= TIMEOUT_LOAD;
                        end else if (timer == 8'd1) begin
                            err_q <= 1'b1;
                            state <= ERR_HOLD;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                end
                ERR_HOLD: begin
                    err_q <= 1'b0;
                    if (!sel_cyc) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/psram_wb_arbiter.md
Name: psram_wb_arbiter

Overview:
- Two-master Wishbone arbiter placed in front of the single-port PSRAM controller.
- Master 0 is the instruction fetch port; master 1 is the load/store data port.
- Grants one master at a time, holds the grant for that master's whole Wishbone cycle, and alternates round-robin on contention.
- Adds a per-transaction watchdog so that a hung PSRAM access returns an error instead of stalling the core forever.

Parameters:
- TIMEOUT_CLKS, 64: clocks from forwarding stb to the PSRAM side without an ack before err is raised; 2..255.
- ADDR_W, 22: address width; matches the PSRAM word address.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset, synchronous, active-high.
- m0_stb_i / m0_cyc_i / m0_we_i, input, 1 each: master 0 Wishbone strobe, cycle, write enable.
- m0_sel_i, input, 4: master 0 byte select.
- m0_addr_i, input, ADDR_W: master 0 address.
- m0_data_i, input, 32: master 0 write data.
- m0_ack_o / m0_err_o, output, 1 each: master 0 acknowledge and error.
- m0_data_o, output, 32: master 0 read data.
- m1_*: same set as m0_*, for master 1.
- s_stb_o / s_cyc_o / s_we_o, output, 1 each: to PSRAM controller.
- s_sel_o, output, 4: to PSRAM controller.
- s_addr_o, output, ADDR_W: to PSRAM controller.
- s_data_o, output, 32: to PSRAM controller.
- s_ack_i, input, 1: ack from PSRAM controller; combinational, drops with stb.
- s_data_i, input, 32: read data from PSRAM controller.

Behaviour:
- Reset values:
  - all m*_ack_o, m*_err_o and s_stb_o/s_cyc_o are 0;
  - m*_data_o = 0;
  - state = IDLE; last_grant = 1, so master 0 wins the first contention; timer = 0.
- States: IDLE, BUSY, ERR_HOLD.
- IDLE:
  - Evaluate req0 = m0_cyc_i & m0_stb_i and req1 = m1_cyc_i & m1_stb_i.
  - Only one request: grant it.
  - Both requests: grant the master that is not last_grant.
  - On grant: register grant, set last_grant, load timer = TIMEOUT_CLKS, go to BUSY.
  - No request: stay in IDLE.
  - One-cycle arbitration latency: s_stb_o rises the clock after the request is seen.
- BUSY:
  - s_* outputs are combinationally muxed from the granted master. s_stb_o = granted stb, s_cyc_o = granted cyc.
  - The non-granted master sees ack = 0 and err = 0.
  - Granted m*_ack_o = s_ack_i, and granted m*_data_o = s_data_i, both combinational with no added latency. This preserves the PSRAM controller's rule that ack drops when stb drops.
  - Grant persists across multiple stb beats while the granted cyc stays high. A master keeping cyc high locks out the other master.
  - Granted cyc falling → IDLE on the next clock. The new arbitration happens in that IDLE cycle.
  - Timer decrements each clock while s_stb_o = 1 and s_ack_i = 0. It reloads to TIMEOUT_CLKS on every s_ack_i.
  - Timer reaching 1 with no ack:
    - drive s_stb_o = 0 and s_cyc_o = 0 (abandons the access);
    - pulse granted m*_err_o for exactly 1 clock (registered);
    - go to ERR_HOLD.
  - Granted master dropping stb mid-wait (protocol abort): forward the drop, no error, stay in BUSY until cyc falls.
- ERR_HOLD:
  - s_cyc_o = 0; stay here until the granted master drops cyc, then go to IDLE.
  - This gives the PSRAM controller at least 1 idle clock to return to standby.
- Width rules: pure passthrough with no data manipulation. The 4-byte split into two 16-bit PSRAM accesses is the PSRAM controller's job.
- rst_i asserted mid-transaction: next clock drops s_stb_o/s_cyc_o and all acks/errs. The PSRAM controller is reset by the same rst_i.
- Simultaneous events:
  - ack and timer expiry in the same cycle: ack wins, no err.
  - new request from the other master during BUSY: held off, no ack; it is served in the next IDLE cycle.
- Fairness: under continuous contention with single-beat cycles, grants strictly alternate 0,1,0,1.

Test Plan:
1. Reset, then m0 reads addr 0x000010 with sel 4'b1111 → s_stb_o rises one clock after the request; m0_ack_o coincides with s_ack_i; m0_data_o = s_data_i = 0xDEADBEEF; m1 sees no ack.
2. m0 and m1 request in the same cycle (m0 read 0x20, m1 write 0x30, data 0x12345678) → m0 served first; s_addr_o = 0x30 and s_data_o = 0x12345678 only after m0 drops cyc and one IDLE clock passes; m1_ack_o then pulses.
3. Both masters continuously re-request single-beat reads for 6 transactions → grant order 0,1,0,1,0,1.
4. TIMEOUT_CLKS = 8 and the slave model never acks → m1_err_o is high for exactly 1 clock 8 clocks after s_stb_o rose; s_cyc_o is 0 in the same clock; state returns to IDLE after m1 drops cyc.
5. s_ack_i arrives on the exact expiry clock → ack delivered, no err.
6. rst_i pulsed while BUSY with a pending m0 write → next clock all s_*/ack/err are 0; the first request after reset is granted to m0 over a simultaneous m1 request.
